lsu_byte: RTL

Load/store unit acting as the initiator side of the data-memory port. It accepts one load or store at a time from the core datapath (LB, LH, LW, LBU, LHU, SB, SH, SW). It drives the memory's address, write-enable, 4-bit byte write-mask and replicated write data. For loads, it captures the memory's one-cycle registered read data and returns it byte- or halfword-extracted and sign- or zero-extended. It sits between the execute stage and the byte-masked synchronous RAM.

---
 rtl/lsu_byte.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/lsu_byte.sv
// Load/store unit: initiator side of a byte-masked synchronous data-memory port.
// One op in flight; loads are lane-extracted and sign/zero-extended in RESP.
module lsu_byte (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_wm,
  input  logic [31:0] mem_rd
);

  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [2:0]    funct3_q;
  logic          we_q;
  logic          err_q;

  logic          req_err;
  logic          take;
  logic [DW-1:0] lane_shift;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] load_data;

  // Request legality, judged from the live request while idle.
  always_comb begin
    req_err = 1'b0;
    if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
      req_err = 1'b1;
    if (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU))
      req_err = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_funct3 == F3_W && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
  end

  assign take = (state == IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (take) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        we_q     <= req_we;
        err_q    <= req_err;
      end
    end
  end

  // Illegal ops skip the memory access and respond straight away.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Load lane extraction from the registered read word.
  always_comb begin
    lane_shift = mem_rd >> {addr_q[1:0], 3'b000};
    rd_byte    = lane_shift[7:0];
    rd_half    = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (funct3_q)
      F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_data = {24'd0, rd_byte};
      F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_data = {16'd0, rd_half};
      F3_W:    load_data = mem_rd;
      default: load_data = '0;
    endcase
  end

  // All outputs decode from registered state; reset forces them quiet.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_a     = '0;
    mem_we    = 1'b0;
    mem_wd    = '0;
    mem_wm    = MW'(0);
    if (!reset) begin
      req_ready = (state == IDLE);
      mem_a     = addr_q;
      mem_we    = we_q && !err_q && (state == ACCESS);
      case (funct3_q)
        F3_B:    mem_wd = {4{wdata_q[7:0]}};
        F3_H:    mem_wd = {2{wdata_q[15:0]}};
        default: mem_wd = wdata_q;
      endcase
      if (state == ACCESS && we_q && !err_q) begin
        case (funct3_q)
          F3_B:    mem_wm = 4'b0001 << addr_q[1:0];
          F3_H:    mem_wm = addr_q[1] ? 4'b1100 : 4'b0011;
          F3_W:    mem_wm = 4'b1111;
          default: mem_wm = 4'b0000;
        endcase
      end
      if (state == RESP) begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q) rsp_rdata = load_data;
      end
    end
  end

endmodule
